// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I core.
// - core_state_t   : sequencer state encoding
// - instructions_t : packed one-hot instruction flags, lui (MSB) .. and (LSB)
// - opcode / funct3 / funct7 constants
// - decode_flags() / decode_imm() : pure decode helpers used by the datapath
package core_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    WRITE   = 3'd4,
    INVALID = 3'd5
  } core_state_t;

  // xor/or/and are SV keywords, hence the trailing underscore on those three.
  typedef struct packed {
    logic lui;  logic auipc; logic jal;  logic jalr;
    logic beq;  logic bne;   logic blt;  logic bge;  logic bltu; logic bgeu;
    logic lb;   logic lh;    logic lw;   logic lbu;  logic lhu;
    logic sb;   logic sh;    logic sw;
    logic addi; logic slti;  logic sltiu; logic xori; logic ori; logic andi;
    logic slli; logic srli;  logic srai;
    logic add;  logic sub;   logic sll;  logic slt;  logic sltu;
    logic xor_; logic srl;   logic sra;  logic or_;  logic and_;
  } instructions_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'd0;  // also beq, lb, sb, jalr
  localparam logic [2:0] F3_SLL  = 3'd1;  // also bne, lh, sh
  localparam logic [2:0] F3_SLT  = 3'd2;  // also lw, sw
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;  // also blt, lbu
  localparam logic [2:0] F3_SR   = 3'd5;  // also bge, lhu
  localparam logic [2:0] F3_OR   = 3'd6;  // also bltu
  localparam logic [2:0] F3_AND  = 3'd7;  // also bgeu

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;  // sub / sra / srai

  function automatic instructions_t decode_flags(input logic [31:0] ir);
    instructions_t f;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       base;
    logic       alt;
    opc  = ir[6:0];
    f3   = ir[14:12];
    f7   = ir[31:25];
    base = (f7 == F7_BASE);
    alt  = (f7 == F7_ALT);
    f    = '0;
    case (opc)
      OPC_LUI:    f.lui   = 1'b1;
      OPC_AUIPC:  f.auipc = 1'b1;
      OPC_JAL:    f.jal   = 1'b1;
      OPC_JALR:   f.jalr  = (f3 == F3_ADD);
      OPC_BRANCH: begin
        f.beq  = (f3 == 3'd0);
        f.bne  = (f3 == 3'd1);
        f.blt  = (f3 == 3'd4);
        f.bge  = (f3 == 3'd5);
        f.bltu = (f3 == 3'd6);
        f.bgeu = (f3 == 3'd7);
      end
      OPC_LOAD: begin
        f.lb  = (f3 == 3'd0);
        f.lh  = (f3 == 3'd1);
        f.lw  = (f3 == 3'd2);
        f.lbu = (f3 == 3'd4);
        f.lhu = (f3 == 3'd5);
      end
      OPC_STORE: begin
        f.sb = (f3 == 3'd0);
        f.sh = (f3 == 3'd1);
        f.sw = (f3 == 3'd2);
      end
      OPC_OP_IMM: begin
        f.addi  = (f3 == F3_ADD);
        f.slti  = (f3 == F3_SLT);
        f.sltiu = (f3 == F3_SLTU);
        f.xori  = (f3 == F3_XOR);
        f.ori   = (f3 == F3_OR);
        f.andi  = (f3 == F3_AND);
        f.slli  = (f3 == F3_SLL) && base;
        f.srli  = (f3 == F3_SR)  && base;
        f.srai  = (f3 == F3_SR)  && alt;
      end
      OPC_OP: begin
        f.add  = (f3 == F3_ADD)  && base;
        f.sub  = (f3 == F3_ADD)  && alt;
        f.sll  = (f3 == F3_SLL)  && base;
        f.slt  = (f3 == F3_SLT)  && base;
        f.sltu = (f3 == F3_SLTU) && base;
        f.xor_ = (f3 == F3_XOR)  && base;
        f.srl  = (f3 == F3_SR)   && base;
        f.sra  = (f3 == F3_SR)   && alt;
        f.or_  = (f3 == F3_OR)   && base;
        f.and_ = (f3 == F3_AND)  && base;
      end
      default: f = '0;
    endcase
    return f;
  endfunction

  // Immediate format is chosen by opcode; anything not S/B/U/J uses the I form.
  function automatic logic [31:0] decode_imm(input logic [31:0] ir);
    case (ir[6:0])
      OPC_STORE:           return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:          return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:  return {ir[31:12], 12'b0};
      OPC_JAL:             return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:             return {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/rv32i_decode_exec_if.sv
// Bus between the fetch/sequencer logic and the decode/execute datapath.
// master : sequencer side (drives state, instruction, pc, register write-back)
// slave  : rv32i_decode_exec (drives decoded fields, register reads, execute results)
interface rv32i_decode_exec_if;
  import core_pkg::*;

  core_state_t   state;
  logic [31:0]   instr_raw;
  logic [31:0]   pc;
  logic          w_enable;
  logic [4:0]    w_addr;
  logic [31:0]   w_data;

  instructions_t instr;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [31:0]   imm;
  logic [31:0]   rs1_v;
  logic [31:0]   rs2_v;
  logic [31:0]   result;
  logic          mem_read_enabled;
  logic          mem_write_enabled;
  logic          reg_write_enabled;
  logic [4:0]    reg_write_dest;
  logic          is_jump_enabled;
  logic [31:0]   jump_dest;

  modport master (
    output state, instr_raw, pc, w_enable, w_addr, w_data,
    input  instr, rd, rs1, rs2, imm, rs1_v, rs2_v, result,
           mem_read_enabled, mem_write_enabled, reg_write_enabled,
           reg_write_dest, is_jump_enabled, jump_dest
  );

  modport slave (
    input  state, instr_raw, pc, w_enable, w_addr, w_data,
    output instr, rd, rs1, rs2, imm, rs1_v, rs2_v, result,
           mem_read_enabled, mem_write_enabled, reg_write_enabled,
           reg_write_dest, is_jump_enabled, jump_dest
  );
endinterface

// File: rtl/rv_regfile.sv
// 32 x 32-bit integer register file, two combinational read ports, one write port.
// Ports: clk, rst (sync, active-high), we_i/waddr_i/wdata_i write port,
//        raddr1_i/raddr2_i read addresses, rdata1_o/rdata2_o read data.
// x0 reads 0 and ignores writes. No write-to-read bypass: a read in the same
// cycle as a write to that register returns the old value until the edge.
module rv_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];

  // NOTE: the array is reset because the core relies on every register
  // starting at 0; that forces flops rather than a RAM macro.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];

endmodule

// File: rtl/rv32i_decode_exec.sv
// Decode, register-file and execute datapath of the multi-cycle RV32I core.
// Ports: clk, rst (sync, active-high), bus (rv32i_decode_exec_if.slave).
// - DECODE edge: latches instr flags, rd/rs1/rs2 and imm from bus.instr_raw.
// - EXEC edge  : latches result, jump decision/target and MEM/WRITE enables.
// - Otherwise both register groups hold. Register writes come from bus.w_*.
module rv32i_decode_exec
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  rv32i_decode_exec_if.slave bus
);

  // Decode registers
  instructions_t instr_q;
  logic [4:0]    rd_q, rs1_q, rs2_q;
  logic [31:0]   imm_q;

  // Execute registers
  logic [31:0] result_q,     result_d;
  logic        mem_read_q,   mem_read_d;
  logic        mem_write_q,  mem_write_d;
  logic        reg_write_q,  reg_write_d;
  logic [4:0]  wr_dest_q,    wr_dest_d;
  logic        jump_q,       jump_d;
  logic [31:0] jump_dest_q,  jump_dest_d;

  logic [31:0] rs1_v, rs2_v;

  rv_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (bus.w_enable),
    .waddr_i  (bus.w_addr),
    .wdata_i  (bus.w_data),
    .raddr1_i (rs1_q),
    .raddr2_i (rs2_q),
    .rdata1_o (rs1_v),
    .rdata2_o (rs2_v)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
    end else if (bus.state == DECODE) begin
      instr_q <= decode_flags(bus.instr_raw);
      rd_q    <= bus.instr_raw[11:7];
      rs1_q   <= bus.instr_raw[19:15];
      rs2_q   <= bus.instr_raw[24:20];
      imm_q   <= decode_imm(bus.instr_raw);
    end
  end

  // Shared operand paths
  logic [31:0] pc_imm, rs1_imm;
  logic [4:0]  shamt_i, shamt_r;
  logic        lt_s, lt_u, eq;
  logic        lt_s_imm, lt_u_imm;

  assign pc_imm   = bus.pc + imm_q;
  assign rs1_imm  = rs1_v + imm_q;
  assign shamt_i  = imm_q[4:0];
  assign shamt_r  = rs2_v[4:0];
  assign eq       = (rs1_v == rs2_v);
  assign lt_s     = ($signed(rs1_v) < $signed(rs2_v));
  assign lt_u     = (rs1_v < rs2_v);
  assign lt_s_imm = ($signed(rs1_v) < $signed(imm_q));
  assign lt_u_imm = (rs1_v < imm_q);

  logic is_load, is_store, is_branch, is_alu;
  assign is_load   = instr_q.lb | instr_q.lh | instr_q.lw | instr_q.lbu | instr_q.lhu;
  assign is_store  = instr_q.sb | instr_q.sh | instr_q.sw;
  assign is_branch = instr_q.beq | instr_q.bne | instr_q.blt | instr_q.bge |
                     instr_q.bltu | instr_q.bgeu;
  assign is_alu    = instr_q.addi | instr_q.slti | instr_q.sltiu | instr_q.xori |
                     instr_q.ori | instr_q.andi | instr_q.slli | instr_q.srli |
                     instr_q.srai | instr_q.add | instr_q.sub | instr_q.sll |
                     instr_q.slt | instr_q.sltu | instr_q.xor_ | instr_q.srl |
                     instr_q.sra | instr_q.or_ | instr_q.and_;

  // Flags are one-hot (or all zero for an unknown instruction), so at most
  // one of the result assignments below is active.
  // NOTE: every output gets a default first so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    result_d    = '0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = instr_q.lui | instr_q.auipc | instr_q.jal | instr_q.jalr |
                  is_load | is_alu;
    wr_dest_d   = rd_q;
    jump_d      = 1'b0;
    jump_dest_d = '0;

    if (instr_q.lui)   result_d = imm_q;
    if (instr_q.auipc) result_d = pc_imm;
    if (instr_q.jal) begin
      result_d    = bus.pc + 32'd4;
      jump_d      = 1'b1;
      jump_dest_d = pc_imm;
    end
    if (instr_q.jalr) begin
      result_d    = bus.pc + 32'd4;
      jump_d      = 1'b1;
      jump_dest_d = rs1_imm & ~32'd1;
    end
    if (is_branch) begin
      jump_dest_d = pc_imm;
      jump_d      = (instr_q.beq  &  eq)   | (instr_q.bne  & ~eq)   |
                    (instr_q.blt  &  lt_s) | (instr_q.bge  & ~lt_s) |
                    (instr_q.bltu &  lt_u) | (instr_q.bgeu & ~lt_u);
    end
    if (is_load) begin
      result_d   = rs1_imm;
      mem_read_d = 1'b1;
    end
    if (is_store) begin
      result_d    = rs1_imm;
      mem_write_d = 1'b1;
    end

    if (instr_q.addi)  result_d = rs1_imm;
    if (instr_q.slti)  result_d = {31'd0, lt_s_imm};
    if (instr_q.sltiu) result_d = {31'd0, lt_u_imm};
    if (instr_q.xori)  result_d = rs1_v ^ imm_q;
    if (instr_q.ori)   result_d = rs1_v | imm_q;
    if (instr_q.andi)  result_d = rs1_v & imm_q;
    if (instr_q.slli)  result_d = rs1_v << shamt_i;
    if (instr_q.srli)  result_d = rs1_v >> shamt_i;
    if (instr_q.srai)  result_d = 32'($signed(rs1_v) >>> shamt_i);

    if (instr_q.add)   result_d = rs1_v + rs2_v;
    if (instr_q.sub)   result_d = rs1_v - rs2_v;
    if (instr_q.sll)   result_d = rs1_v << shamt_r;
    if (instr_q.slt)   result_d = {31'd0, lt_s};
    if (instr_q.sltu)  result_d = {31'd0, lt_u};
    if (instr_q.xor_)  result_d = rs1_v ^ rs2_v;
    if (instr_q.srl)   result_d = rs1_v >> shamt_r;
    if (instr_q.sra)   result_d = 32'($signed(rs1_v) >>> shamt_r);
    if (instr_q.or_)   result_d = rs1_v | rs2_v;
    if (instr_q.and_)  result_d = rs1_v & rs2_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      wr_dest_q   <= '0;
      jump_q      <= 1'b0;
      jump_dest_q <= '0;
    end else if (bus.state == EXEC) begin
      result_q    <= result_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      wr_dest_q   <= wr_dest_d;
      jump_q      <= jump_d;
      jump_dest_q <= jump_dest_d;
    end
  end

  assign bus.instr             = instr_q;
  assign bus.rd                = rd_q;
  assign bus.rs1               = rs1_q;
  assign bus.rs2               = rs2_q;
  assign bus.imm               = imm_q;
  assign bus.rs1_v             = rs1_v;
  assign bus.rs2_v             = rs2_v;
  assign bus.result            = result_q;
  assign bus.mem_read_enabled  = mem_read_q;
  assign bus.mem_write_enabled = mem_write_q;
  assign bus.reg_write_enabled = reg_write_q;
  assign bus.reg_write_dest    = wr_dest_q;
  assign bus.is_jump_enabled   = jump_q;
  assign bus.jump_dest         = jump_dest_q;

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Directed testbench for rv32i_decode_exec: hand-encoded instructions and
// hand-computed expected values; inputs change and outputs are sampled on
// the falling clock edge.
module tb_rv32i_decode_exec;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rv32i_decode_exec_if bus ();

  rv32i_decode_exec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.state    = FETCH;
    bus.w_enable = 1'b1;
    bus.w_addr   = addr;
    bus.w_data   = data;
    @(negedge clk);
    bus.w_enable = 1'b0;
  endtask

  // DECODE edge, EXEC edge, then sit in MEM where all outputs are valid.
  task automatic run(input logic [31:0] raw, input logic [31:0] pc_val);
    @(negedge clk);
    bus.state     = DECODE;
    bus.instr_raw = raw;
    @(negedge clk);
    bus.state = EXEC;
    bus.pc    = pc_val;
    @(negedge clk);
    bus.state = MEM;
  endtask

  instructions_t exp_f;

  initial begin
    bus.state     = FETCH;
    bus.instr_raw = '0;
    bus.pc        = '0;
    bus.w_enable  = 1'b0;
    bus.w_addr    = '0;
    bus.w_data    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_instr",  bus.instr, 0);
    check("rst_imm",    bus.imm, 0);
    check("rst_result", bus.result, 0);
    check("rst_enables", {bus.mem_read_enabled, bus.mem_write_enabled,
                          bus.reg_write_enabled, bus.is_jump_enabled}, 0);
    check("rst_jdest",  bus.jump_dest, 0);

    // Register file: x0 ignores writes, x5 holds its value
    write_reg(5'd0, 32'd5);
    write_reg(5'd5, 32'h1234_5678);
    run(32'h0050_01B3, 32'h0);              // add x3, x0, x5
    check("rf_x0",      bus.rs1_v, 0);
    check("rf_x5",      bus.rs2_v, 32'h1234_5678);
    check("add_result", bus.result, 32'h1234_5678);

    // No bypass: same-cycle write shows old value until the edge
    @(negedge clk);
    bus.w_enable = 1'b1;
    bus.w_addr   = 5'd5;
    bus.w_data   = 32'hCAFE_F00D;
    #1;
    check("rf_no_bypass", bus.rs2_v, 32'h1234_5678);
    @(negedge clk);
    bus.w_enable = 1'b0;
    check("rf_after_edge", bus.rs2_v, 32'hCAFE_F00D);

    // ADDI x1, x0, -1
    run(32'hFFF0_0093, 32'h0);
    exp_f = '0; exp_f.addi = 1'b1;
    check("addi_flags",  bus.instr, exp_f);
    check("addi_rd",     bus.rd, 5'd1);
    check("addi_imm",    bus.imm, 32'hFFFF_FFFF);
    check("addi_result", bus.result, 32'hFFFF_FFFF);
    check("addi_rwe",    bus.reg_write_enabled, 1'b1);
    check("addi_dest",   bus.reg_write_dest, 5'd1);

    // Branches with equal operands
    write_reg(5'd1, 32'd7);
    write_reg(5'd2, 32'd7);
    run(32'h0020_8463, 32'h100);            // beq x1, x2, +8
    check("beq_taken", bus.is_jump_enabled, 1'b1);
    check("beq_dest",  bus.jump_dest, 32'h108);
    run(32'h0020_9463, 32'h100);            // bne x1, x2, +8
    check("bne_taken", bus.is_jump_enabled, 1'b0);
    check("bne_rwe",   bus.reg_write_enabled, 1'b0);

    // Store sw x2, 4(x1)
    write_reg(5'd1, 32'h1000);
    run(32'h0020_A223, 32'h0);
    check("sw_result", bus.result, 32'h1004);
    check("sw_mwe",    bus.mem_write_enabled, 1'b1);
    check("sw_mre",    bus.mem_read_enabled, 1'b0);
    check("sw_rwe",    bus.reg_write_enabled, 1'b0);
    check("sw_data",   bus.rs2_v, 32'd7);

    // JALR x1, 3(x5): bit 0 of the target is cleared
    write_reg(5'd5, 32'h200);
    run(32'h0032_80E7, 32'h40);
    check("jalr_dest",   bus.jump_dest, 32'h202);
    check("jalr_result", bus.result, 32'h44);
    check("jalr_rwe",    bus.reg_write_enabled, 1'b1);
    check("jalr_taken",  bus.is_jump_enabled, 1'b1);

    // Shifts (amount = 33 & 31 = 1) and signed/unsigned compares
    write_reg(5'd1, 32'h8000_0000);
    write_reg(5'd2, 32'd33);
    run(32'h4020_D1B3, 32'h0);              // sra x3, x1, x2
    check("sra_result", bus.result, 32'hC000_0000);
    run(32'h0020_D1B3, 32'h0);              // srl x3, x1, x2
    check("srl_result", bus.result, 32'h4000_0000);
    run(32'h0020_A1B3, 32'h0);              // slt  -> negative < 33
    check("slt_result", bus.result, 32'd1);
    run(32'h0020_B1B3, 32'h0);              // sltu -> 0x80000000 > 33
    check("sltu_result", bus.result, 32'd0);
    run(32'h0020_C463, 32'h100);            // blt taken
    check("blt_taken", bus.is_jump_enabled, 1'b1);
    run(32'h0020_E463, 32'h100);            // bltu not taken
    check("bltu_taken", bus.is_jump_enabled, 1'b0);

    // Unknown opcode
    run(32'hFFFF_FFFF, 32'h100);
    check("unk_flags",  bus.instr, 0);
    check("unk_result", bus.result, 0);
    check("unk_enables", {bus.mem_read_enabled, bus.mem_write_enabled,
                          bus.reg_write_enabled, bus.is_jump_enabled}, 0);

    // Reset asserted during EXEC discards the instruction and clears registers
    @(negedge clk);
    bus.state     = DECODE;
    bus.instr_raw = 32'hFFF0_0093;
    @(negedge clk);
    bus.state = EXEC;
    rst       = 1'b1;
    @(negedge clk);
    check("rstx_instr",  bus.instr, 0);
    check("rstx_rd",     bus.rd, 0);
    check("rstx_imm",    bus.imm, 0);
    check("rstx_result", bus.result, 0);
    check("rstx_rwe",    bus.reg_write_enabled, 1'b0);
    rst       = 1'b0;
    bus.state = FETCH;
    run(32'h0050_01B3, 32'h0);              // add x3, x0, x5 after reset
    check("rstx_regs",   bus.rs2_v, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
